// File: rtl/mem_lock_arbiter.sv
// rtl/mem_lock_arbiter.sv - round-robin arbiter for the shared memory port and a hardware lock table
module mem_lock_arbiter #(
  parameter int C  = 8,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int NL = 16,
  parameter int LW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [C-1:0]  main_mem_read_request,
  input  logic [C-1:0]  main_mem_write_request,
  input  logic [AW-1:0] main_mem_read_adr  [C],
  input  logic [AW-1:0] main_mem_write_adr [C],
  input  logic [DW-1:0] main_mem_write_dat [C],
  output logic [C-1:0]  main_mem_ac,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdat,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [LW-1:0] lock_adr [C],
  input  logic [C-1:0]  lock_en,
  input  logic [C-1:0]  unlock_en,
  output logic [C-1:0]  lock_ac,
  output logic [NL-1:0] lock_held,
  output logic          lock_err
);

  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW:0] C_EXT = (CW+1)'(C);

  // (a + b) mod C for core indices, valid for any C
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= C_EXT) s = s - C_EXT;
    return s[CW-1:0];
  endfunction

  // First eligible core scanning upward from ptr; result is {found, index}
  function automatic logic [CW:0] rr_pick(input logic [C-1:0] elig, input logic [CW-1:0] ptr);
    logic [CW:0]   r;
    logic [CW-1:0] idx;
    r = '0;
    for (int k = C - 1; k >= 0; k--) begin
      idx = wrap_add(ptr, CW'(k));
      if (elig[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [C-1:0]  mem_ac_q, mem_ac_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_wdat_q, mem_wdat_d;
  logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [CW-1:0] mem_ptr_q, mem_ptr_d;
  logic [C-1:0]  lock_ac_q, lock_ac_d;
  logic [CW-1:0] lock_ptr_q, lock_ptr_d;
  logic [NL-1:0] held_q, held_d;
  logic [CW-1:0] owner_q [NL];
  logic [CW-1:0] owner_d [NL];
  logic          lock_err_q, lock_err_d;

  logic [C-1:0]  mem_elig, lk_elig;
  logic [CW:0]   mem_sel, lk_sel;
  logic [CW-1:0] mem_win, lk_win;
  logic [LW-1:0] lk_a;

  // A core just acked is masked so a not-yet-dropped request is not granted twice
  assign mem_elig = (main_mem_read_request | main_mem_write_request) & ~mem_ac_q;
  assign mem_sel  = rr_pick(mem_elig, mem_ptr_q);
  assign mem_win  = mem_sel[CW-1:0];

  // Memory grant: writes take priority over a simultaneous read from the same core
  always_comb begin
    mem_ac_d   = '0;
    mem_adr_d  = mem_adr_q;
    mem_wdat_d = mem_wdat_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    mem_ptr_d  = mem_ptr_q;
    if (mem_sel[CW]) begin
      mem_ac_d[mem_win] = 1'b1;
      mem_ptr_d         = wrap_add(mem_win, CW'(1));
      if (main_mem_write_request[mem_win]) begin
        mem_we_d   = 1'b1;
        mem_adr_d  = main_mem_write_adr[mem_win];
        mem_wdat_d = main_mem_write_dat[mem_win];
      end else begin
        mem_re_d  = 1'b1;
        mem_adr_d = main_mem_read_adr[mem_win];
      end
    end
  end

  // Lock eligibility: unlocks always proceed, acquires only if the entry is free or already ours
  always_comb begin
    lk_elig = '0;
    for (int i = 0; i < C; i++) begin
      lk_elig[i] = ~lock_ac_q[i] & (unlock_en[i] |
                   (lock_en[i] & (~held_q[lock_adr[i]] | (owner_q[lock_adr[i]] == CW'(i)))));
    end
  end

  assign lk_sel = rr_pick(lk_elig, lock_ptr_q);
  assign lk_win = lk_sel[CW-1:0];
  assign lk_a   = lock_adr[lk_win];

  // Lock table update for the granted operation; bad unlocks are acked but flagged
  always_comb begin
    held_d     = held_q;
    owner_d    = owner_q;
    lock_err_d = lock_err_q;
    lock_ac_d  = '0;
    lock_ptr_d = lock_ptr_q;
    if (lk_sel[CW]) begin
      lock_ac_d[lk_win] = 1'b1;
      lock_ptr_d        = wrap_add(lk_win, CW'(1));
      if (unlock_en[lk_win]) begin
        if (held_q[lk_a] && (owner_q[lk_a] == lk_win)) held_d[lk_a] = 1'b0;
        else lock_err_d = 1'b1;
      end else if (!held_q[lk_a]) begin
        held_d[lk_a]  = 1'b1;
        owner_d[lk_a] = lk_win;
      end
    end
  end

  // State register; reset drops any in-flight grant and releases every lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ac_q   <= '0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_ptr_q  <= '0;
      lock_ac_q  <= '0;
      lock_ptr_q <= '0;
      held_q     <= '0;
      owner_q    <= '{default: '0};
      lock_err_q <= 1'b0;
    end else begin
      mem_ac_q   <= mem_ac_d;
      mem_adr_q  <= mem_adr_d;
      mem_wdat_q <= mem_wdat_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_ptr_q  <= mem_ptr_d;
      lock_ac_q  <= lock_ac_d;
      lock_ptr_q <= lock_ptr_d;
      held_q     <= held_d;
      owner_q    <= owner_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign main_mem_ac = mem_ac_q;
  assign mem_adr     = mem_adr_q;
  assign mem_wdat    = mem_wdat_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign lock_ac     = lock_ac_q;
  assign lock_held   = held_q;
  assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// tb/tb_mem_lock_arbiter.sv - directed and randomized self-checking bench for mem_lock_arbiter
module tb_mem_lock_arbiter;
  localparam int C = 8, AW = 16, DW = 16, NL = 16, LW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [C-1:0]  rd_req, wr_req, l_en, u_en;
  logic [AW-1:0] rd_adr [C];
  logic [AW-1:0] wr_adr [C];
  logic [DW-1:0] wr_dat [C];
  logic [LW-1:0] l_adr  [C];
  logic [C-1:0]  mem_ac, lock_ac;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdat;
  logic          mem_we, mem_re, lock_err;
  logic [NL-1:0] lock_held;

  mem_lock_arbiter #(.C(C), .AW(AW), .DW(DW), .NL(NL), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .main_mem_read_request(rd_req), .main_mem_write_request(wr_req),
    .main_mem_read_adr(rd_adr), .main_mem_write_adr(wr_adr), .main_mem_write_dat(wr_dat),
    .main_mem_ac(mem_ac), .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_re(mem_re),
    .lock_adr(l_adr), .lock_en(l_en), .unlock_en(u_en),
    .lock_ac(lock_ac), .lock_held(lock_held), .lock_err(lock_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: integer pointers, per-lock owner array, last shown grants
  int       m_mem_ptr, m_lock_ptr;
  bit [C-1:0] m_mem_ac, m_lock_ac;
  bit       m_held [NL];
  int       m_owner [NL];
  bit       m_err, e_we, e_re;
  int       e_adr, e_wdat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] held_vec();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) if (m_held[k]) v = v | (32'd1 << k);
    return v;
  endfunction

  task automatic model_reset();
    m_mem_ptr = 0; m_lock_ptr = 0; m_mem_ac = '0; m_lock_ac = '0;
    m_err = 0; e_we = 0; e_re = 0; e_adr = 0; e_wdat = 0;
    for (int k = 0; k < NL; k++) begin m_held[k] = 0; m_owner[k] = 0; end
  endtask

  task automatic model_eval();
    int win, lw, i, a;
    bit ok;
    win = -1;
    for (int k = 0; k < C; k++) begin
      i = (m_mem_ptr + k) % C;
      if (win < 0 && (rd_req[i] || wr_req[i]) && !m_mem_ac[i]) win = i;
    end
    m_mem_ac = '0; e_we = 0; e_re = 0;
    if (win >= 0) begin
      m_mem_ac[win] = 1'b1;
      if (wr_req[win]) begin e_we = 1; e_adr = int'(wr_adr[win]); e_wdat = int'(wr_dat[win]); end
      else begin e_re = 1; e_adr = int'(rd_adr[win]); end
      m_mem_ptr = (win + 1) % C;
    end
    lw = -1;
    for (int k = 0; k < C; k++) begin
      i = (m_lock_ptr + k) % C;
      a = int'(l_adr[i]);
      ok = u_en[i] || (l_en[i] && (!m_held[a] || m_owner[a] == i));
      if (lw < 0 && ok && !m_lock_ac[i]) lw = i;
    end
    m_lock_ac = '0;
    if (lw >= 0) begin
      m_lock_ac[lw] = 1'b1;
      a = int'(l_adr[lw]);
      if (u_en[lw]) begin
        if (m_held[a] && m_owner[a] == lw) m_held[a] = 0;
        else m_err = 1;
      end else if (!m_held[a]) begin
        m_held[a] = 1; m_owner[a] = lw;
      end
      m_lock_ptr = (lw + 1) % C;
    end
  endtask

  task automatic compare_all();
    check("main_mem_ac", 32'(mem_ac), 32'(m_mem_ac));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_adr", 32'(mem_adr), 32'(e_adr));
    check("mem_wdat", 32'(mem_wdat), 32'(e_wdat));
    check("lock_ac", 32'(lock_ac), 32'(m_lock_ac));
    check("lock_held", 32'(lock_held), held_vec());
    check("lock_err", 32'(lock_err), 32'(m_err));
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rd_req = '0; wr_req = '0; l_en = '0; u_en = '0;
    for (int k = 0; k < C; k++) begin
      rd_adr[k] = '0; wr_adr[k] = '0; wr_dat[k] = '0; l_adr[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_mem_ac", 32'(mem_ac), 32'd0);
    check("rst_we_re", 32'({mem_we, mem_re}), 32'd0);
    check("rst_adr", 32'(mem_adr), 32'd0);
    check("rst_lock_ac", 32'(lock_ac), 32'd0);
    check("rst_held", 32'(lock_held), 32'd0);
    check("rst_err", 32'(lock_err), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic gen_random();
    int r, own;
    for (int i = 0; i < C; i++) begin
      if (m_mem_ac[i] && $urandom_range(0, 7) != 0) begin
        if (e_we) wr_req[i] = 1'b0; else rd_req[i] = 1'b0;
      end
      if (!rd_req[i] && $urandom_range(0, 3) == 0) begin
        rd_req[i] = 1'b1; rd_adr[i] = AW'($urandom);
      end
      if (!wr_req[i] && $urandom_range(0, 5) == 0) begin
        wr_req[i] = 1'b1; wr_adr[i] = AW'($urandom); wr_dat[i] = DW'($urandom);
      end
      if (m_lock_ac[i] && $urandom_range(0, 7) != 0) begin
        l_en[i] = 1'b0; u_en[i] = 1'b0;
      end
      if (!l_en[i] && !u_en[i]) begin
        r = int'($urandom_range(0, 9));
        own = -1;
        for (int k = 0; k < 4; k++) if (m_held[k] && m_owner[k] == i) own = k;
        if (r == 0 || r == 1) begin l_en[i] = 1'b1; l_adr[i] = LW'($urandom_range(0, 3)); end
        else if (r == 2 && own >= 0) begin u_en[i] = 1'b1; l_adr[i] = LW'(own); end
        else if (r == 3) begin u_en[i] = 1'b1; l_adr[i] = LW'($urandom_range(0, 4)); end
        else if (r == 4) begin l_en[i] = 1'b1; u_en[i] = 1'b1; l_adr[i] = LW'($urandom_range(0, 3)); end
      end
    end
  endtask

  initial begin
    int got;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // single read from core 0
    rd_req[0] = 1'b1; rd_adr[0] = 16'h0040;
    cycle();
    check("t1_ac", 32'(mem_ac), 32'h01);
    check("t1_adr", 32'(mem_adr), 32'h0040);
    check("t1_re_we", 32'({mem_re, mem_we}), 32'b10);
    rd_req[0] = 1'b0;
    cycle();
    check("t1_ac_drop", 32'(mem_ac), 32'h00);

    // all cores requesting continuously: strict rotation
    do_reset();
    for (int k = 0; k < C; k++) begin rd_req[k] = 1'b1; rd_adr[k] = AW'(k * 16); end
    for (int k = 0; k <= C; k++) begin
      cycle();
      check("t2_rr_seq", 32'(mem_ac), 32'd1 << (k % C));
    end
    clear_inputs();
    cycle();

    // write and read together: write first, read later
    do_reset();
    wr_req[2] = 1'b1; wr_adr[2] = 16'h0010; wr_dat[2] = 16'hBEEF;
    rd_req[2] = 1'b1; rd_adr[2] = 16'h0020;
    cycle();
    check("t3_w_ac", 32'(mem_ac), 32'h04);
    check("t3_w_we_re", 32'({mem_we, mem_re}), 32'b10);
    check("t3_w_adr", 32'(mem_adr), 32'h0010);
    check("t3_w_dat", 32'(mem_wdat), 32'hBEEF);
    wr_req[2] = 1'b0;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (got == 0 && mem_ac[2]) begin
        got = 1;
        check("t3_r_re_we", 32'({mem_re, mem_we}), 32'b10);
        check("t3_r_adr", 32'(mem_adr), 32'h0020);
        rd_req[2] = 1'b0;
      end
    end
    check("t3_read_granted", 32'(got), 32'd1);
    clear_inputs();
    cycle();

    // lock contention on lock 3
    do_reset();
    l_en[1] = 1'b1; l_adr[1] = 4'd3;
    cycle();
    check("t4_acq1", 32'(lock_ac), 32'h02);
    check("t4_held3", 32'(lock_held[3]), 32'd1);
    l_en[1] = 1'b0;
    l_en[4] = 1'b1; l_adr[4] = 4'd3;
    l_en[6] = 1'b1; l_adr[6] = 4'd5;
    cycle();
    check("t4_core6_bypass", 32'(lock_ac), 32'h40);
    l_en[6] = 1'b0;
    cycle();
    check("t4_core4_waits", 32'(lock_ac), 32'h00);
    u_en[1] = 1'b1;
    cycle();
    check("t4_unlock1", 32'(lock_ac), 32'h02);
    u_en[1] = 1'b0;
    cycle();
    check("t4_core4_acq", 32'(lock_ac), 32'h10);
    check("t4_held3_again", 32'(lock_held[3]), 32'd1);
    check("t4_no_err", 32'(lock_err), 32'd0);
    l_en[4] = 1'b0;

    // unlock of a free lock: acked, flagged, sticky
    u_en[5] = 1'b1; l_adr[5] = 4'd7;
    cycle();
    check("t5_ac", 32'(lock_ac), 32'h20);
    check("t5_held", 32'(lock_held), 32'h0028);
    check("t5_err", 32'(lock_err), 32'd1);
    u_en[5] = 1'b0;
    repeat (3) cycle();
    check("t5_err_sticky", 32'(lock_err), 32'd1);

    // asynchronous reset mid-operation
    rd_req[5] = 1'b1;
    cycle();
    check("t6_pre_ac", 32'(mem_ac), 32'h20);
    rd_req[5] = 1'b0; rd_req[0] = 1'b1; rd_req[6] = 1'b1;
    #2;
    do_reset();
    cycle();
    check("t6_post_ac", 32'(mem_ac), 32'h01);
    check("t6_post_held", 32'(lock_held), 32'd0);
    clear_inputs();
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      gen_random();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lock_arbiter.md
Name: mem_lock_arbiter

Overview:
- Shares the single main memory port and a 16-entry hardware lock table among C cores.
- Each cycle, one memory access is granted by round-robin arbitration. Separately, one lock operation per cycle is granted by its own round-robin arbiter.
- Sits between the core array and main_mem and drives the per-core main_mem_ac and lock_ac handshakes.
- Memory is clocked on the inverted clock, so registered outputs are stable by the mid-cycle edge.

Parameters:
- C, 8, number of requesting cores.
- AW, 16, memory address width.
- DW, 16, memory data width.
- NL, 16, number of locks; lock index width LW = $clog2(NL) = 4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- main_mem_read_request  in  C  per-core read request, level, held until acked.
- main_mem_write_request  in  C  per-core write request, level, held until acked.
- main_mem_read_adr  in  AW x C (unpacked)  per-core read address.
- main_mem_write_adr  in  AW x C (unpacked)  per-core write address.
- main_mem_write_dat  in  DW x C (unpacked)  per-core write data.
- main_mem_ac  out  C  one-hot memory grant, 1-cycle pulse.
- mem_adr  out  AW  address to main_mem.
- mem_wdat  out  DW  write data to main_mem.
- mem_we  out  1  write enable to main_mem.
- mem_re  out  1  read strobe to main_mem.
- lock_adr  in  LW x C (unpacked)  per-core lock index.
- lock_en  in  C  per-core acquire request, level.
- unlock_en  in  C  per-core release request, level.
- lock_ac  out  C  one-hot lock grant, 1-cycle pulse.
- lock_held  out  NL  status: lock k currently owned.
- lock_err  out  1  sticky illegal-unlock flag.

Behaviour:

Reset:
- While reset is high, asynchronously clear all outputs to 0, clear the lock table (held and owner fields), and set both round-robin pointers to 0.
- Reset may assert mid-transaction. Any pending or in-flight grant is dropped, and all locks are released.

Memory arbitration:
- Core i is eligible when (read_request[i] | write_request[i]) is set and main_mem_ac[i] was not asserted in the current cycle. This mask prevents double-granting a request the core has not yet dropped.
- The winner is the first eligible core scanning upward from mem_ptr, wrapping modulo C.
- At the posedge following the request, register all of:
  - main_mem_ac = onehot(winner);
  - mem_adr;
  - mem_wdat;
  - mem_we / mem_re;
  - mem_ptr = (winner+1) mod C.
- Latency: request sampled in cycle N produces the grant in cycle N+1. Read data is valid on the shared main_mem_dat during cycle N+1.
- If the winner asserts both read and write, the write is serviced: mem_we=1, mem_re=0, mem_adr=write_adr. The read stays pending.
- With no eligible core, main_mem_ac=0, mem_we=0, mem_re=0, and mem_adr/mem_wdat hold their previous values.
- Fairness: a continuously requesting core is granted within C cycles.
- Cores must drop their request in the cycle they see ack. A request still high in the following cycle counts as a new request.

Lock table:
- Each entry k holds a held bit and an owner index ($clog2(C) bits).
- Core i is lock-eligible when either:
  - unlock_en[i] is set (unlock_en wins if both are asserted); or
  - lock_en[i] is set and entry lock_adr[i] is free or already owned by i.
- Cores waiting on a lock held by another core are skipped, so they never block other cores.
- One lock operation is granted per cycle by round-robin from lock_ptr. At the posedge:
  - lock_ac = onehot(winner);
  - the table is updated;
  - lock_ptr = (winner+1) mod C.
- Acquire on a free entry: set held, set owner to the winner.
- Acquire by the current owner: acked, no state change.
- Unlock by the owner: clear held; acked.
- Unlock of a free entry or by a non-owner: acked, table unchanged, lock_err set (sticky until reset).
- After an unlock granted in cycle N, the released lock can be granted to another core in cycle N+1 at the earliest.
- A core that sees lock_ac must drop its request. The same masking rule as for memory applies: no grant to core i in the cycle after its lock_ac.
- lock_held is a registered copy of the held bits.

Test Plan:
1. Core 0 issues a read of 0x0040 in cycle 0 → cycle 1: main_mem_ac=0x01, mem_adr=0x0040, mem_re=1, mem_we=0; core drops request; cycle 2: main_mem_ac=0x00.
2. All 8 cores hold read requests continuously → main_mem_ac sequence 0x01,0x02,…,0x80,0x01. No core waits more than 8 cycles, and no core gets two grants within 8 cycles.
3. Core 2 asserts write (adr 0x0010, dat 0xBEEF) and read (adr 0x0020) together → first grant has mem_we=1, mem_adr=0x0010, mem_wdat=0xBEEF. The later grant has mem_re=1, mem_adr=0x0020.
4. Lock contention on lock 3:
   - Core 1 acquires lock 3 → lock_ac=0x02, lock_held[3]=1.
   - Core 4 requests lock 3 → no ack while core 1 holds it.
   - Meanwhile core 6 acquires lock 5 → acked without waiting on core 4.
   - Core 1 unlocks lock 3 → acked in cycle N.
   - Core 4 is acked in cycle N+1, owner=4, lock_held[3]=1.
5. Core 5 unlocks free lock 7 → lock_ac=0x20, lock_held unchanged, lock_err=1 and stays 1 until reset.
6. Asynchronous reset pulse mid-operation, with locks 3 and 5 held and a pending grant → all outputs 0 immediately. After release, the first memory grant goes to the lowest-index requester (pointer=0), and lock_held=0.
